// File: rtl/mac_accumulator_bank.sv
// Three-stage multiply-accumulate engine with a private accumulator bank.
// Supports MAC, MSU, LOAD and CLR with optional saturation on overflow.
module mac_accumulator_bank #(
    parameter int DATA_WIDTH     = 32,
    parameter int ACC_WIDTH      = 5,
    parameter int ACC_DATA_WIDTH = 64,
    parameter int SATURATE       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic                      is_signed,
    input  logic [DATA_WIDTH-1:0]     src1,
    input  logic [DATA_WIDTH-1:0]     src2,
    input  logic [ACC_WIDTH-1:0]      accumulator_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_DATA_WIDTH-1:0] result_out,
    output logic [ACC_WIDTH-1:0]      result_addr,
    output logic                      overflow
);

    localparam int DW    = DATA_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int AW    = ACC_WIDTH;
    localparam int ADW   = ACC_DATA_WIDTH;
    localparam int DEPTH = 1 << ACC_WIDTH;

    localparam logic [1:0] OP_MAC  = 2'b00;
    localparam logic [1:0] OP_MSU  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic           r_s1_valid;
    logic [1:0]     r_s1_op;
    logic           r_s1_sgn;
    logic [DW-1:0]  r_s1_a;
    logic [DW-1:0]  r_s1_b;
    logic [AW-1:0]  r_s1_addr;

    logic           r_s2_valid;
    logic [1:0]     r_s2_op;
    logic           r_s2_sgn;
    logic [PW-1:0]  r_s2_prod;
    logic [AW-1:0]  r_s2_addr;

    logic           r_out_valid;
    logic [ADW-1:0] r_result;
    logic [AW-1:0]  r_addr;
    logic           r_ovf;
    logic [ADW-1:0] r_bank [DEPTH];

    logic           w_stall;
    logic           w_adv;
    logic [PW-1:0]  w_ext_a;
    logic [PW-1:0]  w_ext_b;
    logic [PW-1:0]  w_prod;
    logic [ADW-1:0] w_acc;
    logic [ADW-1:0] w_p;
    logic [ADW:0]   w_ax;
    logic [ADW:0]   w_px;
    logic [ADW:0]   w_ex;
    logic [ADW-1:0] w_next;
    logic           w_ovf;

    assign w_stall  = r_out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_MAC;
            r_s1_sgn   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_addr  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op   <= op;
                r_s1_sgn  <= is_signed;
                r_s1_a    <= src1;
                r_s1_b    <= src2;
                r_s1_addr <= accumulator_addr;
            end
        end
    end

    // Extending both operands to PW bits lets one multiplier serve both modes.
    assign w_ext_a = r_s1_sgn ? {{DW{r_s1_a[DW-1]}}, r_s1_a}
                              : {{DW{1'b0}}, r_s1_a};
    assign w_ext_b = r_s1_sgn ? {{DW{r_s1_b[DW-1]}}, r_s1_b}
                              : {{DW{1'b0}}, r_s1_b};
    assign w_prod  = w_ext_a * w_ext_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= OP_MAC;
            r_s2_sgn   <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_addr  <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_op   <= r_s1_op;
                r_s2_sgn  <= r_s1_sgn;
                r_s2_prod <= w_prod;
                r_s2_addr <= r_s1_addr;
            end
        end
    end

    assign w_acc = r_bank[r_s2_addr];

    always_comb begin
        if (r_s2_sgn) w_p = ADW'($signed(r_s2_prod));
        else          w_p = ADW'(r_s2_prod);
    end

    // One extra bit holds the exact sum/difference for overflow detection.
    assign w_ax = {r_s2_sgn & w_acc[ADW-1], w_acc};
    assign w_px = {r_s2_sgn & w_p[ADW-1], w_p};

    always_comb begin
        w_ex   = '0;
        w_next = '0;
        w_ovf  = 1'b0;
        unique case (r_s2_op)
            OP_MAC, OP_MSU: begin
                w_ex   = (r_s2_op == OP_MSU) ? (w_ax - w_px) : (w_ax + w_px);
                w_ovf  = r_s2_sgn ? (w_ex[ADW] ^ w_ex[ADW-1]) : w_ex[ADW];
                w_next = w_ex[ADW-1:0];
                if (w_ovf && (SATURATE != 0)) begin
                    if (r_s2_sgn)
                        w_next = w_ex[ADW] ? {1'b1, {(ADW-1){1'b0}}}
                                           : {1'b0, {(ADW-1){1'b1}}};
                    else
                        w_next = (r_s2_op == OP_MSU) ? '0 : '1;
                end
            end
            OP_LOAD: w_next = w_p;
            OP_CLR:  w_next = '0;
            default: w_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_addr      <= '0;
            r_ovf       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_result            <= w_next;
                r_addr              <= r_s2_addr;
                r_ovf               <= w_ovf;
                r_bank[r_s2_addr]   <= w_next;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign result_out  = r_result;
    assign result_addr = r_addr;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_mac_accumulator_bank.sv
// Directed bench for mac_accumulator_bank: latency, chaining, signed,
// saturation, backpressure and mid-stream reset.
module tb_mac_accumulator_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic        is_signed = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  accumulator_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result_out;
    logic [4:0]  result_addr;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] MAC = 2'b00;
    localparam logic [1:0] MSU = 2'b01;
    localparam logic [1:0] LD  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    mac_accumulator_bank #(
        .DATA_WIDTH(32), .ACC_WIDTH(5), .ACC_DATA_WIDTH(64), .SATURATE(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_signed(is_signed), .src1(src1), .src2(src2),
        .accumulator_addr(accumulator_addr), .out_valid(out_valid),
        .out_ready(out_ready), .result_out(result_out),
        .result_addr(result_addr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ad);
        op = o; is_signed = s; src1 = a; src2 = b; accumulator_addr = ad;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [63:0] res,
                              input logic [4:0] ad, input logic ov);
        int n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".res"}, result_out, res);
        chk({tag, ".addr"}, result_addr, ad);
        chk({tag, ".ovf"}, overflow, ov);
        tick();
    endtask

    int sent, got, hold;
    bit seen;

    initial begin
        tick(); tick();
        chk("rst.valid", out_valid, 0);
        chk("rst.res", result_out, 0);
        chk("rst.addr", result_addr, 0);
        chk("rst.ovf", overflow, 0);
        rst = 1'b1;
        tick();
        chk("rst.ready", in_ready, 1);

        issue(MAC, 0, 32'h10, 32'h20, 5'd14);
        chk("lat.c1", out_valid, 0);
        tick();
        chk("lat.c2", out_valid, 0);
        tick();
        chk("lat.c3", out_valid, 1);
        chk("lat.res", result_out, 64'h200);
        chk("lat.addr", result_addr, 14);
        tick();
        chk("lat.drop", out_valid, 0);

        issue(MAC, 0, 32'h1, 32'h2, 5'd14);
        expect_res("mac2", 64'h202, 5'd14, 0);

        op = MAC; is_signed = 0; src1 = 3; src2 = 5; accumulator_addr = 3;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4);
            tick();
            if (k >= 2) begin
                chk("b2b.valid", out_valid, 1);
                chk("b2b.res", result_out, 64'(15 * (k - 1)));
                chk("b2b.ovf", overflow, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("b2b.end", out_valid, 0);

        issue(LD, 1, 32'hFFFF_FFFE, 32'd3, 5'd0);
        expect_res("sld", 64'hFFFF_FFFF_FFFF_FFFA, 5'd0, 0);
        issue(MSU, 1, 32'd1, 32'd1, 5'd0);
        expect_res("smsu", 64'hFFFF_FFFF_FFFF_FFF9, 5'd0, 0);
        issue(CLR, 1, 32'h1234, 32'h5678, 5'd0);
        expect_res("sclr", 64'h0, 5'd0, 0);

        issue(LD, 1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        expect_res("ssat.ld", 64'h4000_0000_0000_0000, 5'd1, 0);
        issue(MAC, 1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        expect_res("ssat.mac", 64'h7FFF_FFFF_FFFF_FFFF, 5'd1, 1);

        issue(LD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        expect_res("usat.ld", 64'hFFFF_FFFE_0000_0001, 5'd7, 0);
        issue(MAC, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        expect_res("usat.mac", 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1);
        issue(CLR, 0, 32'h0, 32'h0, 5'd7);
        expect_res("usat.clr", 64'h0, 5'd7, 0);
        issue(MSU, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        expect_res("usat.msu", 64'h0, 5'd7, 1);

        sent = 0; got = 0; hold = 0; seen = 0;
        op = MAC; is_signed = 0; src1 = 1; src2 = 1; accumulator_addr = 9;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (out_valid && !seen) begin
                seen = 1;
                hold = 5;
            end
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < 6);
            #1;
            if (!out_ready) begin
                chk("bp.vhold", out_valid, 1);
                chk("bp.rdy", in_ready, 0);
                chk("bp.hold", result_out, 64'd1);
                chk("bp.ahold", result_addr, 9);
            end
            if (out_valid && out_ready) begin
                chk("bp.seq", result_out, 64'(got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp.got", 64'(got), 6);
        chk("bp.sent", 64'(sent), 6);
        chk("bp.nodup", out_valid, 0);

        op = MAC; is_signed = 0; src1 = 1; src2 = 1; accumulator_addr = 5;
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mrst.valid", out_valid, 0);
        chk("mrst.res", result_out, 0);
        chk("mrst.addr", result_addr, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mrst.flush", out_valid, 0);
        end
        issue(MAC, 0, 32'd2, 32'd2, 5'd14);
        expect_res("mrst.mac", 64'd4, 5'd14, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
